// File: rtl/serial_alu_pkg.sv
// -----------------------------------------------------------------------------
// serial_alu_pkg
// Shared definitions for the bit-serial ALU sequencer:
//   - FSM state encodings (ST_IDLE / ST_RUN / ST_DONE) and the state enum
//   - Adder-slice operation constants (OP_ADD, OP_XOR) as {S, M} pairs
// -----------------------------------------------------------------------------
package serial_alu_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE = ST_IDLE,
        S_RUN  = ST_RUN,
        S_DONE = ST_DONE
    } state_e;

    typedef struct packed {
        logic [3:0] s;
        logic       m;
    } slice_op_t;

    // Arithmetic add: S=1001, M=0. Logic XOR: S=0110, M=1.
    localparam slice_op_t OP_ADD = '{s: 4'b1001, m: 1'b0};
    localparam slice_op_t OP_XOR = '{s: 4'b0110, m: 1'b1};

endpackage

// File: rtl/serial_alu_controller_shift_reg.sv
// -----------------------------------------------------------------------------
// serial_shift_reg
// Right-shifting register with parallel load. Used for both operands (serial
// out at bit 0) and for the result (serial in at the MSB).
// Ports:
//   clk, rst      : clock, synchronous active-high reset (clears contents)
//   load          : load parallel_in (has priority over shift)
//   parallel_in   : WIDTH-bit load value
//   shift         : shift right by one, serial_in enters at the MSB
//   serial_in     : bit inserted at the MSB on shift
//   serial_out    : current bit 0
//   parallel_out  : full register contents
// -----------------------------------------------------------------------------
module serial_shift_reg #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] parallel_in,
    input  logic             shift,
    input  logic             serial_in,
    output logic             serial_out,
    output logic [WIDTH-1:0] parallel_out
);

    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d;

    always_comb begin
        data_d = data_q;
        if (load) begin
            data_d = parallel_in;
        end else if (shift) begin
            data_d = {serial_in, data_q[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign serial_out   = data_q[0];
    assign parallel_out = data_q;

endmodule

// File: rtl/serial_alu_controller.sv
// -----------------------------------------------------------------------------
// serial_alu_controller
// Bit-serial sequencer driving an external single-bit Adder slice across a
// WIDTH-bit operation, LSB first. The slice carry-out is fed back as the next
// carry-in; result bits are shifted in at the MSB.
// Optional build macro: ZERO_FLAG_EN adds the 'zero' output (result == 0).
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   start           : request an operation (accepted in IDLE or DONE)
//   op_s, op_m      : slice function select / mode, latched on start
//   carry_in        : initial carry for bit 0
//   opa, opb        : operands
//   busy            : high while the operation runs
//   done            : one-cycle pulse, result/carry_out valid
//   result          : assembled result, held until the next accepted start
//   carry_out       : slice Pout after the MSB
//   zero            : (ZERO_FLAG_EN only) result is all zeros
//   slice_a/b       : operand bits to the slice
//   slice_S/M       : latched function select / mode
//   slice_Pin       : carry flop to the slice
//   slice_F/Pout    : slice result bit / carry-out
// -----------------------------------------------------------------------------
module serial_alu_controller
    import serial_alu_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       op_s,
    input  logic             op_m,
    input  logic             carry_in,
    input  logic [WIDTH-1:0] opa,
    input  logic [WIDTH-1:0] opb,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
`ifdef ZERO_FLAG_EN
    output logic             zero,
`endif
    output logic             slice_a,
    output logic             slice_b,
    output logic [3:0]       slice_S,
    output logic             slice_M,
    output logic             slice_Pin,
    input  logic             slice_F,
    input  logic             slice_Pout
);

    localparam int unsigned CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic [3:0]       sel_s_q, sel_s_d;
    logic             sel_m_q, sel_m_d;
    logic             cout_q, cout_d;

    logic             load;
    logic             shift;

    logic             opa_bit, opb_bit, res_bit;
    logic [WIDTH-1:0] opa_par, opb_par, res_par;

`ifdef ZERO_FLAG_EN
    logic sticky_q, sticky_d;
    logic zero_q, zero_d;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        sel_s_d = sel_s_q;
        sel_m_d = sel_m_q;
        cout_d  = cout_q;
        load    = 1'b0;
        shift   = 1'b0;
`ifdef ZERO_FLAG_EN
        sticky_d = sticky_q;
        zero_d   = zero_q;
`endif
        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d = S_RUN;
                    load    = 1'b1;
                    cnt_d   = '0;
                    carry_d = carry_in;
                    sel_s_d = op_s;
                    sel_m_d = op_m;
`ifdef ZERO_FLAG_EN
                    sticky_d = 1'b0;
`endif
                end else if (state_q == S_DONE) begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                shift   = 1'b1;
                carry_d = slice_Pout;
                cnt_d   = cnt_q + CNT_W'(1);
`ifdef ZERO_FLAG_EN
                sticky_d = sticky_q | slice_F;
`endif
                if (cnt_q == CNT_LAST) begin
                    state_d = S_DONE;
                    cout_d  = slice_Pout;
`ifdef ZERO_FLAG_EN
                    // Include the MSB's F, which the sticky flop has not seen yet.
                    zero_d = ~(sticky_q | slice_F);
`endif
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            sel_s_q <= '0;
            sel_m_q <= 1'b0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            sel_s_q <= sel_s_d;
            sel_m_q <= sel_m_d;
            cout_q  <= cout_d;
        end
    end

`ifdef ZERO_FLAG_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            sticky_q <= 1'b0;
            zero_q   <= 1'b0;
        end else begin
            sticky_q <= sticky_d;
            zero_q   <= zero_d;
        end
    end

    assign zero = zero_q;
`endif

    serial_shift_reg #(.WIDTH(WIDTH)) u_opa_sr (
        .clk          (clk),
        .rst          (rst),
        .load         (load),
        .parallel_in  (opa),
        .shift        (shift),
        .serial_in    (1'b0),
        .serial_out   (opa_bit),
        .parallel_out (opa_par)
    );

    serial_shift_reg #(.WIDTH(WIDTH)) u_opb_sr (
        .clk          (clk),
        .rst          (rst),
        .load         (load),
        .parallel_in  (opb),
        .shift        (shift),
        .serial_in    (1'b0),
        .serial_out   (opb_bit),
        .parallel_out (opb_par)
    );

    // Result register: cleared on start, slice_F enters at the MSB each RUN cycle.
    serial_shift_reg #(.WIDTH(WIDTH)) u_res_sr (
        .clk          (clk),
        .rst          (rst),
        .load         (load),
        .parallel_in  ('0),
        .shift        (shift),
        .serial_in    (slice_F),
        .serial_out   (res_bit),
        .parallel_out (res_par)
    );

    // Only the serial side of the operands and the parallel side of the result
    // are consumed.
    logic unused_sr_bits;
    assign unused_sr_bits = ^{opa_par, opb_par, res_bit};

    assign busy      = (state_q == S_RUN);
    assign done      = (state_q == S_DONE);
    assign result    = res_par;
    assign carry_out = cout_q;
    assign slice_a   = opa_bit;
    assign slice_b   = opb_bit;
    assign slice_S   = sel_s_q;
    assign slice_M   = sel_m_q;
    assign slice_Pin = carry_q;

endmodule

// File: tb/tb_serial_alu_controller.sv
// -----------------------------------------------------------------------------
// tb_serial_alu_controller
// Scoreboard bench: accepted operations push their hand-computed result into a
// queue; a monitor pops and compares on every done pulse. An Adder slice model
// (add / xor) closes the loop on the slice_* ports.
// -----------------------------------------------------------------------------
module tb_serial_alu_controller;

    localparam int unsigned WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [3:0]       op_s;
    logic             op_m;
    logic             carry_in;
    logic [WIDTH-1:0] opa, opb;
    logic             busy, done, carry_out;
    logic [WIDTH-1:0] result;
    logic             slice_a, slice_b, slice_M, slice_Pin;
    logic [3:0]       slice_S;
    logic             slice_F, slice_Pout;
`ifdef ZERO_FLAG_EN
    logic             zero;
`endif

    int unsigned errors = 0;
    int unsigned checks = 0;

    typedef struct {
        logic [WIDTH-1:0] res;
        logic             cout;
        logic             zero;
    } exp_t;

    exp_t exp_q[$];

    always #5 clk = ~clk;

    serial_alu_controller #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .op_s       (op_s),
        .op_m       (op_m),
        .carry_in   (carry_in),
        .opa        (opa),
        .opb        (opb),
        .busy       (busy),
        .done       (done),
        .result     (result),
        .carry_out  (carry_out),
`ifdef ZERO_FLAG_EN
        .zero       (zero),
`endif
        .slice_a    (slice_a),
        .slice_b    (slice_b),
        .slice_S    (slice_S),
        .slice_M    (slice_M),
        .slice_Pin  (slice_Pin),
        .slice_F    (slice_F),
        .slice_Pout (slice_Pout)
    );

    // Adder slice model.
    always_comb begin
        slice_F    = 1'b0;
        slice_Pout = 1'b0;
        if (slice_S == 4'b1001 && slice_M == 1'b0) begin
            slice_F    = slice_a ^ slice_b ^ slice_Pin;
            slice_Pout = (slice_a & slice_b) | (slice_a & slice_Pin) | (slice_b & slice_Pin);
        end else if (slice_S == 4'b0110 && slice_M == 1'b1) begin
            slice_F    = slice_a ^ slice_b;
            slice_Pout = slice_Pin;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (done) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_done", 32'(done), 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("result", 32'(result), 32'(e.res));
                chk("carry_out", 32'(carry_out), 32'(e.cout));
`ifdef ZERO_FLAG_EN
                chk("zero", 32'(zero), 32'(e.zero));
`endif
            end
        end
    end

    // Issue one operation starting right after the next rising edge, then
    // follow it through RUN and DONE. mid_start pulses an ignored start at
    // RUN cycle 3.
    task automatic run_op(input logic [3:0] s, input logic m, input logic cin,
                          input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input logic [WIDTH-1:0] er, input logic ec, input logic ez,
                          input bit mid_start);
        exp_t e;
        @(posedge clk);
        #1;
        start = 1'b1; op_s = s; op_m = m; carry_in = cin; opa = a; opb = b;
        e.res = er; e.cout = ec; e.zero = ez;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int i = 1; i <= int'(WIDTH); i++) begin
            @(negedge clk);
            chk("busy_run", 32'(busy), 32'd1);
            chk("done_run", 32'(done), 32'd0);
            chk("slice_S_run", 32'(slice_S), 32'(s));
            chk("slice_M_run", 32'(slice_M), 32'(m));
            if (mid_start && i == 3) begin
                start = 1'b1; opa = 8'h11; op_s = 4'b0110; op_m = 1'b1;
            end else if (mid_start && i == 4) begin
                start = 1'b0;
            end
        end
        @(negedge clk);
        chk("done_pulse", 32'(done), 32'd1);
        chk("busy_at_done", 32'(busy), 32'd0);
        repeat (2) begin
            @(negedge clk);
            chk("done_one_cycle", 32'(done), 32'd0);
            chk("result_held", 32'(result), 32'(er));
            chk("carry_held", 32'(carry_out), 32'(ec));
        end
    endtask

    initial begin
        bit seen;
        exp_t e;
        rst = 1'b1; start = 1'b0; op_s = '0; op_m = 1'b0; carry_in = 1'b0;
        opa = '0; opb = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ctrl", 32'({busy, done, carry_out}), 32'd0);
        chk("rst_result", 32'(result), 32'd0);
        chk("rst_slice", 32'({slice_a, slice_b, slice_S, slice_M, slice_Pin}), 32'd0);
`ifdef ZERO_FLAG_EN
        chk("rst_zero", 32'(zero), 32'd0);
`endif
        rst = 1'b0;

        // Add, no carry
        run_op(4'b1001, 1'b0, 1'b0, 8'h35, 8'h4A, 8'h7F, 1'b0, 1'b0, 1'b0);
        // Add, wrap
        run_op(4'b1001, 1'b0, 1'b0, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b1, 1'b0);
        run_op(4'b1001, 1'b0, 1'b1, 8'hFF, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0);
        // Logic XOR, carry chain passes Pin through
        run_op(4'b0110, 1'b1, 1'b0, 8'hA5, 8'h0F, 8'hAA, 1'b0, 1'b0, 1'b0);
        // start during RUN ignored
        run_op(4'b1001, 1'b0, 1'b0, 8'h35, 8'h4A, 8'h7F, 1'b0, 1'b0, 1'b1);

        // Back-to-back: start during the done cycle
        @(posedge clk);
        #1;
        start = 1'b1; op_s = 4'b1001; op_m = 1'b0; carry_in = 1'b0; opa = 8'h35; opb = 8'h4A;
        e.res = 8'h7F; e.cout = 1'b0; e.zero = 1'b0;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (WIDTH) @(negedge clk);
        @(negedge clk);
        chk("b2b_first_done", 32'(done), 32'd1);
        start = 1'b1; opa = 8'h11; opb = 8'h22;
        e.res = 8'h33; e.cout = 1'b0; e.zero = 1'b0;
        exp_q.push_back(e);
        @(negedge clk);
        chk("b2b_busy", 32'(busy), 32'd1);
        start = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        chk("b2b_second_done", 32'(seen), 32'd1);

        // Reset mid-operation: no done, everything back to reset values
        @(posedge clk);
        #1;
        start = 1'b1; op_s = 4'b1001; op_m = 1'b0; carry_in = 1'b1; opa = 8'h35; opb = 8'h4A;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_ctrl", 32'({busy, done, carry_out}), 32'd0);
        chk("abort_result", 32'(result), 32'd0);
        chk("abort_slice", 32'({slice_a, slice_b, slice_S, slice_M, slice_Pin}), 32'd0);
        rst = 1'b0;
        seen = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        chk("abort_no_done", 32'(seen), 32'd0);

        // Normal operation after the abort
        run_op(4'b1001, 1'b0, 1'b0, 8'h11, 8'h22, 8'h33, 1'b0, 1'b0, 1'b0);

        repeat (3) @(negedge clk);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
